fu_sched: RTL and testbench
===========================

Name: fu_sched

Overview:
- Function-unit scheduler between the issue queue and the execution lanes.
- Generates the per-class `fu_ready[4:0]` mask consumed by the issue queue, and returns the per-port `issue` accept signals.
- Maps accepted issue ports onto physical execution lanes.
- Tracks occupancy of shared or limited units:
  - non-pipelined divider (busy FSM),
  - load/store unit (credit counter),
  - multiplier (per-cycle slot limit).

Parameters:
- iwd, 2, issue ports.
- ewd, 2, execution lanes.
- opsz, 32, operation ID window size (redirect age compare).
- lsq_cr, 8, LSU credits (free load/store queue entries at reset).
- mul_n, 1, multiplier issues accepted per cycle.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- iss_bundle  in  iss_bundle_t[iwd]  issue candidates; valid = opid[15]; uses .opid and .fu.
- red_bundle  in  red_bundle_t  redirect; valid = opid[15]; uses .opid and .topid.
- div_done  in  1  divider result written back this cycle.
- lsu_ret  in  $clog2(lsq_cr)+1  LSU credits returned this cycle.
- issue  out  iwd  port accepted this cycle.
- fu_ready  out  5  class ready mask: bit0 ALU, bit1 MEM, bit2 BRU, bit3 MUL, bit4 DIV.
- lane_vld  out  ewd  lane carries an op.
- lane_port  out  ewd*$clog2(iwd)  source issue port per lane.
- div_kill  out  1  abort the in-flight divide.

Behaviour:
- Reset (rst=0, asynchronous):
  - div FSM = IDLE; div_opid = 0; lsu credit = lsq_cr; fu_ready = 5'b11111; issue = 0; lane_vld = 0; div_kill = 0.
- fu_ready is registered and reflects state after the current cycle's updates:
  - bits 0 and 2 are always 1.
  - bit1 = (credit != 0).
  - bit3 = 1.
  - bit4 = (next div state == IDLE).
- Acceptance is combinational, in the same cycle, scanning ports from 0 upward. Port i is accepted iff all of:
  - it is valid;
  - its class has capacity remaining this cycle;
  - fewer than ewd ports have been accepted so far;
  - no redirect is valid this cycle (a valid red_bundle forces issue = 0 and lane_vld = 0).
- Per-cycle class capacity:
  - MEM: min(credit, ewd).
  - MUL: mul_n.
  - DIV: 1 if state IDLE, else 0.
  - ALU/BRU: unlimited.
- An op whose fu mask has several bits set uses the lowest-index class that has capacity.
- Lane mapping: the k-th accepted port drives lane k; lane_port[k] = port index; lanes above the accepted count have lane_vld = 0.
- LSU credit update: credit_next = credit − MEM accepts + lsu_ret.
  - Saturate at lsq_cr; overflow is an assertion error.
  - Accepts and returns in the same cycle both apply.
- Div FSM:
  - IDLE → BUSY on DIV accept; latch div_opid.
  - BUSY → IDLE on div_done.
  - BUSY → KILL when a redirect is valid and div_opid is younger than it (shared succeed() age compare).
  - KILL: div_kill = 1 for exactly one cycle, then → IDLE. A div_done arriving in KILL is ignored.
  - div_done and a flushing redirect in the same BUSY cycle: div_done wins → IDLE, no kill.
  - div_done while IDLE is an assertion error.
- Redirect does not alter the credit count. The LSU returns credits for flushed entries through lsu_ret.
- Latency: accept is 0 cycles; fu_ready is updated 1 cycle after the triggering event.
- Mid-operation reset (rst=0): state returns to reset values immediately; no div_kill is generated.

Decomposition:
- Shared types package:
  - FU class bit index constants: FU_ALU = 0, FU_MEM = 1, FU_BRU = 2, FU_MUL = 3, FU_DIV = 4.
  - div_state_t enum {IDLE, BUSY, KILL}.
  - succeed(opid, red opid, topid, opsz) age-compare function, moved from the issue queue into the package so both blocks share it.
- One sub-module, fu_credit: a parameterised saturating credit counter with up/down counts and a nonzero flag, instantiated for the LSU.

Test Plan:
- Reset, then 2 ALU ops on ports 0/1 → issue = 2'b11, lane_port = {1,0}, lane_vld = 2'b11, fu_ready = 5'b11111.
- DIV on port 0 and DIV on port 1 in the same cycle → issue = 2'b01; next cycle fu_ready[4] = 0. div_done 10 cycles later → fu_ready[4] = 1 the following cycle.
- lsq_cr = 2: two MEM accepts with lsu_ret = 0 → next cycle fu_ready[1] = 0, and a MEM op on port 0 gets issue = 0. lsu_ret = 1 → credit 1, fu_ready[1] = 1.
- Div BUSY with div_opid = 0x8005, redirect opid = 0x8003, topid = 0x8000 → div_kill pulses one cycle; IDLE the cycle after.
- Same setup as the previous scenario, but div_done asserted in the same cycle as the redirect → div_kill = 0, IDLE next cycle.
- Valid redirect with 2 valid ALU ops → issue = 0 and lane_vld = 0 that cycle. Assert rst = 0 mid-BUSY → fu_ready = 5'b11111 immediately and credit = lsq_cr.

Source files
------------

// File: rtl/fu_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fu_sched_pkg
// Description : Shared types and helpers for the function-unit scheduler.
//               Function-unit class indices, the divider FSM state type,
//               the issue and redirect bundle layouts, the redirect
//               age-compare function succeed() and a lowest-set-bit helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fu_sched_pkg;

    // Function-unit class bit positions in fu / fu_ready masks
    localparam int FU_ALU = 0;
    localparam int FU_MEM = 1;
    localparam int FU_BRU = 2;
    localparam int FU_MUL = 3;
    localparam int FU_DIV = 4;
    localparam int FU_N   = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        KILL = 2'd2
    } div_state_t;

    // opid[15] is the valid bit; fu is a class mask (one or more bits set)
    typedef struct packed {
        logic [15:0]     opid;
        logic [FU_N-1:0] fu;
    } iss_bundle_t;

    // opid[15] is the valid bit; topid is the oldest op ID still in flight
    typedef struct packed {
        logic [15:0] opid;
        logic [15:0] topid;
    } red_bundle_t;

    // Returns 1 when opid is younger than red_opid. Both IDs are measured as
    // a distance from the oldest in-flight ID (topid) inside a window of
    // opsz IDs, so the compare stays correct across ID wrap-around.
    function automatic logic succeed(
        input logic [15:0] opid,
        input logic [15:0] red_opid,
        input logic [15:0] topid,
        input int unsigned opsz
    );
        logic [15:0] d_op;
        logic [15:0] d_red;
        d_op  = (opid - topid) % 16'(opsz);
        d_red = (red_opid - topid) % 16'(opsz);
        return d_op > d_red;
    endfunction

    // Isolates the lowest set bit of a class mask (two's-complement trick)
    function automatic logic [FU_N-1:0] lowest_set(input logic [FU_N-1:0] m);
        return m & (~m + FU_N'(1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/fu_credit.sv
`default_nettype none
// ============================================================================
// Module      : fu_credit
// Description : Saturating credit counter. Each cycle the count moves by
//               inc_i - dec_i (both may be nonzero) and is clamped at MAX.
//               Resets to MAX (all credits free).
// Ports       : clk       - clock
//               rst       - asynchronous active-low reset
//               inc_i     - credits returned this cycle
//               dec_i     - credits consumed this cycle
//               cnt_o     - current credit count
//               nonzero_o - at least one credit available
// Revision    : 1.0 - initial release
// ============================================================================
module fu_credit #(
    parameter int MAX = 8,
    parameter int CW  = $clog2(MAX) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] inc_i,
    input  logic [CW-1:0] dec_i,
    output logic [CW-1:0] cnt_o,
    output logic          nonzero_o
);

    localparam logic [CW-1:0] c_MAX   = CW'(MAX);
    localparam logic [CW:0]   c_MAX_W = (CW+1)'(MAX);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW:0]   w_sum;

    // One extra bit so that count + returns cannot wrap before the clamp
    always_comb begin
        w_sum = {1'b0, cnt_q} + {1'b0, inc_i} - {1'b0, dec_i};
        cnt_d = (w_sum > c_MAX_W) ? c_MAX : w_sum[CW-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= c_MAX;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign nonzero_o = (cnt_q != '0);

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (w_sum <= c_MAX_W)
                else $error("fu_credit: credit count overflow");
            assert ({1'b0, dec_i} <= {1'b0, cnt_q} + {1'b0, inc_i})
                else $error("fu_credit: credit count underflow");
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/fu_sched.sv
`default_nettype none
// ============================================================================
// Module      : fu_sched
// Description : Function-unit scheduler between issue queue and execution
//               lanes. Accepts issue candidates in port order subject to
//               per-class capacity and lane count, maps accepted ports onto
//               lanes, tracks LSU credits, the non-pipelined divider and the
//               multiplier slot limit, and publishes a registered class
//               ready mask.
// Ports       : clk        - clock
//               rst        - asynchronous active-low reset
//               iss_bundle - issue candidates (valid = opid[15])
//               red_bundle - redirect (valid = opid[15])
//               div_done   - divider writes back this cycle
//               lsu_ret    - LSU credits returned this cycle
//               issue      - per-port accept
//               fu_ready   - class ready mask {DIV,MUL,BRU,MEM,ALU}
//               lane_vld   - lane carries an op
//               lane_port  - source issue port per lane
//               div_kill   - abort the in-flight divide (one-cycle pulse)
// Revision    : 1.0 - initial release
// ============================================================================
module fu_sched
    import fu_sched_pkg::*;
#(
    parameter int IWD    = 2,
    parameter int EWD    = 2,
    parameter int OPSZ   = 32,
    parameter int LSQ_CR = 8,
    parameter int MUL_N  = 1
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  iss_bundle_t [IWD-1:0]                       iss_bundle,
    input  red_bundle_t                                 red_bundle,
    input  logic                                        div_done,
    input  logic [$clog2(LSQ_CR):0]                     lsu_ret,
    output logic [IWD-1:0]                              issue,
    output logic [FU_N-1:0]                             fu_ready,
    output logic [EWD-1:0]                              lane_vld,
    output logic [EWD*((IWD > 1) ? $clog2(IWD) : 1)-1:0] lane_port,
    output logic                                        div_kill
);

    localparam int PW     = (IWD > 1) ? $clog2(IWD) : 1;
    localparam int AW     = $clog2(EWD + 1);
    localparam int CW     = $clog2(LSQ_CR) + 1;
    localparam int MW     = $clog2(MUL_N + 1);
    localparam int MEMCAP = (EWD < LSQ_CR) ? EWD : LSQ_CR;

    localparam logic [AW-1:0] c_EWD    = AW'(EWD);
    localparam logic [MW-1:0] c_MUL_N  = MW'(MUL_N);
    localparam logic [CW-1:0] c_MEMCAP = CW'(MEMCAP);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    div_state_t  div_state_q;
    div_state_t  div_state_d;
    logic [15:0] div_opid_q;
    logic [15:0] div_opid_d;

    logic [CW-1:0] w_credit;
    logic          w_credit_nz;

    // ------------------------------------------------------------------
    // Acceptance scan
    // ------------------------------------------------------------------
    logic                   w_red_vld;
    logic                   w_go;
    logic [IWD-1:0]         w_issue;
    logic [EWD-1:0]         w_lane_vld;
    logic [EWD-1:0][PW-1:0] w_lane_port;
    logic [AW-1:0]          w_nacc;
    logic [CW-1:0]          w_mem_left;
    logic [CW-1:0]          w_mem_acc;
    logic [MW-1:0]          w_mul_left;
    logic                   w_div_left;
    logic                   w_div_acc;
    logic [15:0]            w_div_opid;
    logic [FU_N-1:0]        w_avail;
    logic [FU_N-1:0]        w_req;
    logic [FU_N-1:0]        w_pick;

    assign w_red_vld = red_bundle.opid[15];
    // Nothing issues while held in reset or while a redirect is flushing
    assign w_go      = rst && !w_red_vld;

    // Ports are scanned lowest first; each accept consumes one lane and one
    // unit of capacity from the class it was steered to, so later ports see
    // only what is left.
    always_comb begin
        w_issue     = '0;
        w_lane_vld  = '0;
        w_lane_port = '0;
        w_nacc      = '0;
        w_mem_left  = (w_credit < c_MEMCAP) ? w_credit : c_MEMCAP;
        w_mem_acc   = '0;
        w_mul_left  = c_MUL_N;
        w_div_left  = (div_state_q == IDLE);
        w_div_acc   = 1'b0;
        w_div_opid  = '0;
        w_avail     = '0;
        w_req       = '0;
        w_pick      = '0;
        for (int i = 0; i < IWD; i++) begin
            w_avail         = '1;
            w_avail[FU_MEM] = (w_mem_left != '0);
            w_avail[FU_MUL] = (w_mul_left != '0);
            w_avail[FU_DIV] = w_div_left;
            w_req  = iss_bundle[i].fu & w_avail;
            w_pick = lowest_set(w_req);
            if (w_go && iss_bundle[i].opid[15] && (w_nacc < c_EWD) && (w_req != '0)) begin
                w_issue[i] = 1'b1;
                for (int k = 0; k < EWD; k++) begin
                    if (AW'(k) == w_nacc) begin
                        w_lane_vld[k]  = 1'b1;
                        w_lane_port[k] = PW'(i);
                    end
                end
                w_nacc = w_nacc + AW'(1);
                if (w_pick[FU_MEM]) begin
                    w_mem_left = w_mem_left - CW'(1);
                    w_mem_acc  = w_mem_acc + CW'(1);
                end
                if (w_pick[FU_MUL]) begin
                    w_mul_left = w_mul_left - MW'(1);
                end
                if (w_pick[FU_DIV]) begin
                    w_div_left = 1'b0;
                    w_div_acc  = 1'b1;
                    w_div_opid = iss_bundle[i].opid;
                end
            end
        end
    end

    assign issue     = w_issue;
    assign lane_vld  = w_lane_vld;
    assign lane_port = w_lane_port;

    // ------------------------------------------------------------------
    // LSU credits
    // ------------------------------------------------------------------
    fu_credit #(
        .MAX (LSQ_CR),
        .CW  (CW)
    ) u_lsu_credit (
        .clk       (clk),
        .rst       (rst),
        .inc_i     (lsu_ret),
        .dec_i     (w_mem_acc),
        .cnt_o     (w_credit),
        .nonzero_o (w_credit_nz)
    );

    // ------------------------------------------------------------------
    // Divider FSM
    // ------------------------------------------------------------------
    // A writeback in the same cycle as a flushing redirect completes the
    // divide normally: the result is already on its way, so there is
    // nothing left to abort.
    always_comb begin
        div_state_d = div_state_q;
        div_opid_d  = div_opid_q;
        div_kill    = 1'b0;
        unique case (div_state_q)
            IDLE: begin
                if (w_div_acc) begin
                    div_state_d = BUSY;
                    div_opid_d  = w_div_opid;
                end
            end
            BUSY: begin
                if (div_done) begin
                    div_state_d = IDLE;
                end else if (w_red_vld &&
                             succeed(div_opid_q, red_bundle.opid, red_bundle.topid, OPSZ)) begin
                    div_state_d = KILL;
                end
            end
            KILL: begin
                div_kill    = 1'b1;
                div_state_d = IDLE;
            end
            default: begin
                div_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_state_q <= IDLE;
            div_opid_q  <= '0;
        end else begin
            div_state_q <= div_state_d;
            div_opid_q  <= div_opid_d;
        end
    end

    // ------------------------------------------------------------------
    // Ready mask: a pure function of registered state, so it reflects the
    // previous cycle's accepts/returns and never depends on this cycle's
    // candidates.
    // ------------------------------------------------------------------
    always_comb begin
        fu_ready         = '1;
        fu_ready[FU_MEM] = w_credit_nz;
        fu_ready[FU_DIV] = (div_state_q == IDLE);
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!(div_done && (div_state_q == IDLE)))
                else $error("fu_sched: div_done while divider idle");
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fu_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_fu_sched
// Description : Directed self-checking bench for fu_sched (LSQ_CR = 2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fu_sched;
    import fu_sched_pkg::*;

    localparam int IWD    = 2;
    localparam int EWD    = 2;
    localparam int OPSZ   = 32;
    localparam int LSQ_CR = 2;
    localparam int MUL_N  = 1;

    localparam logic [4:0] M_NONE = 5'b00000;
    localparam logic [4:0] M_ALU  = 5'b00001;
    localparam logic [4:0] M_MEM  = 5'b00010;
    localparam logic [4:0] M_MUL  = 5'b01000;
    localparam logic [4:0] M_DIV  = 5'b10000;

    logic                 clk = 1'b0;
    logic                 rst;
    iss_bundle_t [IWD-1:0] iss;
    red_bundle_t          red;
    logic                 div_done;
    logic [1:0]           lsu_ret;
    logic [IWD-1:0]       issue;
    logic [4:0]           fu_ready;
    logic [EWD-1:0]       lane_vld;
    logic [EWD-1:0]       lane_port;
    logic                 div_kill;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fu_sched #(
        .IWD    (IWD),
        .EWD    (EWD),
        .OPSZ   (OPSZ),
        .LSQ_CR (LSQ_CR),
        .MUL_N  (MUL_N)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .iss_bundle (iss),
        .red_bundle (red),
        .div_done   (div_done),
        .lsu_ret    (lsu_ret),
        .issue      (issue),
        .fu_ready   (fu_ready),
        .lane_vld   (lane_vld),
        .lane_port  (lane_port),
        .div_kill   (div_kill)
    );

    task automatic idle();
        iss      = '0;
        red      = '0;
        div_done = 1'b0;
        lsu_ret  = 2'd0;
    endtask

    task automatic drive(input logic [15:0] o0, input logic [4:0] f0,
                         input logic [15:0] o1, input logic [4:0] f1);
        iss[0].opid = o0;
        iss[0].fu   = f0;
        iss[1].opid = o1;
        iss[1].fu   = f1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        drive(16'h8001, M_ALU, 16'h8002, M_ALU);
        repeat (2) @(negedge clk);
        #1;
        total++; if (issue !== 2'b00) begin bad++; $display("FAIL reset_issue: got %b want 00", issue); end
        total++; if (lane_vld !== 2'b00) begin bad++; $display("FAIL reset_lane_vld: got %b want 00", lane_vld); end
        total++; if (fu_ready !== 5'b11111) begin bad++; $display("FAIL reset_fu_ready: got %b want 11111", fu_ready); end
        total++; if (div_kill !== 1'b0) begin bad++; $display("FAIL reset_div_kill: got %b want 0", div_kill); end
        @(negedge clk);
        rst = 1'b1;
        idle();
    endtask

    task automatic test_alu();
        @(negedge clk);
        drive(16'h8001, M_ALU, 16'h8002, M_ALU);
        #1;
        total++; if (issue !== 2'b11) begin bad++; $display("FAIL alu_issue: got %b want 11", issue); end
        total++; if (lane_vld !== 2'b11) begin bad++; $display("FAIL alu_lane_vld: got %b want 11", lane_vld); end
        total++; if (lane_port !== 2'b10) begin bad++; $display("FAIL alu_lane_port: got %b want 10", lane_port); end
        @(negedge clk);
        idle();
        #1;
        total++; if (fu_ready !== 5'b11111) begin bad++; $display("FAIL alu_fu_ready: got %b want 11111", fu_ready); end
    endtask

    task automatic test_div();
        @(negedge clk);
        drive(16'h8010, M_DIV, 16'h8011, M_DIV);
        #1;
        total++; if (issue !== 2'b01) begin bad++; $display("FAIL div_issue_one: got %b want 01", issue); end
        total++; if (lane_vld !== 2'b01) begin bad++; $display("FAIL div_lane_vld: got %b want 01", lane_vld); end
        @(negedge clk);
        drive(16'h8012, M_DIV, 16'h8013, M_ALU);
        #1;
        total++; if (fu_ready !== 5'b01111) begin bad++; $display("FAIL div_busy_ready: got %b want 01111", fu_ready); end
        total++; if (issue !== 2'b10) begin bad++; $display("FAIL div_busy_issue: got %b want 10", issue); end
        total++; if (lane_vld !== 2'b01) begin bad++; $display("FAIL div_busy_lane_vld: got %b want 01", lane_vld); end
        total++; if (lane_port !== 2'b01) begin bad++; $display("FAIL div_busy_lane_port: got %b want 01", lane_port); end
        @(negedge clk);
        idle();
        repeat (8) @(negedge clk);
        #1;
        total++; if (fu_ready[4] !== 1'b0) begin bad++; $display("FAIL div_still_busy: got %b want 0", fu_ready[4]); end
        div_done = 1'b1;
        @(negedge clk);
        div_done = 1'b0;
        #1;
        total++; if (fu_ready !== 5'b11111) begin bad++; $display("FAIL div_done_ready: got %b want 11111", fu_ready); end
    endtask

    task automatic test_mem();
        @(negedge clk);
        drive(16'h8020, M_MEM, 16'h8021, M_MEM);
        #1;
        total++; if (issue !== 2'b11) begin bad++; $display("FAIL mem_two_issue: got %b want 11", issue); end
        @(negedge clk);
        drive(16'h8022, M_MEM, 16'h0000, M_NONE);
        #1;
        total++; if (fu_ready !== 5'b11101) begin bad++; $display("FAIL mem_empty_ready: got %b want 11101", fu_ready); end
        total++; if (issue !== 2'b00) begin bad++; $display("FAIL mem_empty_issue: got %b want 00", issue); end
        @(negedge clk);
        drive(16'h8023, M_MEM | M_MUL, 16'h8024, M_MUL);
        #1;
        total++; if (issue !== 2'b01) begin bad++; $display("FAIL mul_slot_issue: got %b want 01", issue); end
        total++; if (lane_vld !== 2'b01) begin bad++; $display("FAIL mul_slot_lane_vld: got %b want 01", lane_vld); end
        @(negedge clk);
        idle();
        lsu_ret = 2'd1;
        @(negedge clk);
        lsu_ret = 2'd1;
        drive(16'h8025, M_MEM, 16'h8026, M_MEM);
        #1;
        total++; if (fu_ready !== 5'b11111) begin bad++; $display("FAIL mem_ret_ready: got %b want 11111", fu_ready); end
        total++; if (issue !== 2'b01) begin bad++; $display("FAIL mem_one_credit_issue: got %b want 01", issue); end
        @(negedge clk);
        idle();
        #1;
        total++; if (fu_ready !== 5'b11111) begin bad++; $display("FAIL mem_acc_ret_ready: got %b want 11111", fu_ready); end
        lsu_ret = 2'd1;
        @(negedge clk);
        idle();
    endtask

    task automatic test_kill();
        // Older divide: redirect does not flush it
        @(negedge clk);
        drive(16'h8002, M_DIV, 16'h0000, M_NONE);
        #1;
        total++; if (issue !== 2'b01) begin bad++; $display("FAIL kill_old_issue: got %b want 01", issue); end
        @(negedge clk);
        idle();
        red.opid  = 16'h8003;
        red.topid = 16'h8000;
        drive(16'h8040, M_ALU, 16'h8041, M_ALU);
        #1;
        total++; if (issue !== 2'b00) begin bad++; $display("FAIL red_block_issue: got %b want 00", issue); end
        total++; if (lane_vld !== 2'b00) begin bad++; $display("FAIL red_block_lane_vld: got %b want 00", lane_vld); end
        @(negedge clk);
        idle();
        #1;
        total++; if (div_kill !== 1'b0) begin bad++; $display("FAIL kill_old_nokill: got %b want 0", div_kill); end
        total++; if (fu_ready !== 5'b01111) begin bad++; $display("FAIL kill_old_busy: got %b want 01111", fu_ready); end
        div_done = 1'b1;
        @(negedge clk);
        div_done = 1'b0;
        // Younger divide: flushed
        drive(16'h8005, M_DIV, 16'h0000, M_NONE);
        #1;
        total++; if (issue !== 2'b01) begin bad++; $display("FAIL kill_young_issue: got %b want 01", issue); end
        @(negedge clk);
        idle();
        red.opid  = 16'h8003;
        red.topid = 16'h8000;
        #1;
        total++; if (div_kill !== 1'b0) begin bad++; $display("FAIL kill_early: got %b want 0", div_kill); end
        @(negedge clk);
        idle();
        div_done = 1'b1;
        #1;
        total++; if (div_kill !== 1'b1) begin bad++; $display("FAIL kill_pulse: got %b want 1", div_kill); end
        total++; if (fu_ready !== 5'b01111) begin bad++; $display("FAIL kill_ready: got %b want 01111", fu_ready); end
        @(negedge clk);
        div_done = 1'b0;
        #1;
        total++; if (div_kill !== 1'b0) begin bad++; $display("FAIL kill_one_cycle: got %b want 0", div_kill); end
        total++; if (fu_ready !== 5'b11111) begin bad++; $display("FAIL kill_idle: got %b want 11111", fu_ready); end
    endtask

    task automatic test_done_wins();
        @(negedge clk);
        drive(16'h8005, M_DIV, 16'h0000, M_NONE);
        #1;
        total++; if (issue !== 2'b01) begin bad++; $display("FAIL dw_issue: got %b want 01", issue); end
        @(negedge clk);
        idle();
        red.opid  = 16'h8003;
        red.topid = 16'h8000;
        div_done  = 1'b1;
        @(negedge clk);
        idle();
        #1;
        total++; if (div_kill !== 1'b0) begin bad++; $display("FAIL dw_nokill: got %b want 0", div_kill); end
        total++; if (fu_ready !== 5'b11111) begin bad++; $display("FAIL dw_idle: got %b want 11111", fu_ready); end
        @(negedge clk);
        #1;
        total++; if (div_kill !== 1'b0) begin bad++; $display("FAIL dw_nokill_late: got %b want 0", div_kill); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        drive(16'h8030, M_DIV, 16'h8031, M_MEM);
        #1;
        total++; if (issue !== 2'b11) begin bad++; $display("FAIL rm_issue_a: got %b want 11", issue); end
        @(negedge clk);
        drive(16'h8032, M_MEM, 16'h0000, M_NONE);
        #1;
        total++; if (issue !== 2'b01) begin bad++; $display("FAIL rm_issue_b: got %b want 01", issue); end
        @(negedge clk);
        idle();
        #1;
        total++; if (fu_ready !== 5'b01101) begin bad++; $display("FAIL rm_pre_ready: got %b want 01101", fu_ready); end
        #1;
        rst = 1'b0;
        #1;
        total++; if (fu_ready !== 5'b11111) begin bad++; $display("FAIL rm_reset_ready: got %b want 11111", fu_ready); end
        total++; if (div_kill !== 1'b0) begin bad++; $display("FAIL rm_reset_kill: got %b want 0", div_kill); end
        @(negedge clk);
        rst = 1'b1;
        drive(16'h8033, M_MEM, 16'h8034, M_MEM);
        #1;
        total++; if (issue !== 2'b11) begin bad++; $display("FAIL rm_credit_restored: got %b want 11", issue); end
        @(negedge clk);
        idle();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_div();
        test_mem();
        test_kill();
        test_done_wins();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
